// File: rtl/dma_arbiter_if.sv
// Bundles the requester-side and DMA-side signals of the DMA arbiter.
// The arbiter connects through the slave modport; the requester/DMA side uses master.
interface dma_arbiter_if #(
  parameter int NUM_REQ           = 2,
  parameter int MEM_ADDRESS_WIDTH = 10
);
  logic [NUM_REQ-1:0]                   i_req;
  logic [NUM_REQ*MEM_ADDRESS_WIDTH-1:0] i_req_address;
  logic [NUM_REQ*MEM_ADDRESS_WIDTH-1:0] i_req_count;
  logic                                 i_dma_ready;
  logic [NUM_REQ-1:0]                   o_grant;
  logic [NUM_REQ-1:0]                   o_done;
  logic                                 o_error;
  logic                                 o_busy;
  logic                                 o_dma_read;
  logic [MEM_ADDRESS_WIDTH-1:0]         o_dma_address;
  logic [MEM_ADDRESS_WIDTH-1:0]         o_dma_count;

  modport slave (
    input  i_req, i_req_address, i_req_count, i_dma_ready,
    output o_grant, o_done, o_error, o_busy, o_dma_read, o_dma_address, o_dma_count
  );

  modport master (
    output i_req, i_req_address, i_req_count, i_dma_ready,
    input  o_grant, o_done, o_error, o_busy, o_dma_read, o_dma_address, o_dma_count
  );
endinterface

// File: rtl/dma_arbiter.sv
// Round-robin arbiter sharing one DMA read engine between NUM_REQ requesters,
// with count validation and a watchdog that abandons transfers the DMA never completes.
module dma_arbiter #(
  parameter int NUM_REQ           = 2,
  parameter int MEM_ADDRESS_WIDTH = 10,
  parameter int BUFFER_SIZE       = 120,
  parameter int TIMEOUT           = 1023
) (
  input logic          clk,
  input logic          rst,
  dma_arbiter_if.slave bus
);
  localparam int AW = MEM_ADDRESS_WIDTH;
  localparam int PW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         r_state;
  logic [PW-1:0]      r_ptr;
  logic [PW-1:0]      r_owner;
  logic [TW-1:0]      r_timer;
  logic [NUM_REQ-1:0] r_grant;
  logic [NUM_REQ-1:0] r_done;
  logic               r_error;
  logic               r_busy;
  logic               r_dma_read;
  logic [AW-1:0]      r_address;
  logic [AW-1:0]      r_count;

  logic               w_found;
  logic [PW-1:0]      w_winner;
  logic [AW-1:0]      w_address;
  logic [AW-1:0]      w_count;
  logic               w_legal;
  logic [PW-1:0]      w_next_ptr;

  // Scan upward from the pointer with wrap, so the pointer position has top priority.
  always_comb begin
    int            w_idx;
    logic [PW-1:0] w_sel;
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = 0;
    w_sel    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = int'(r_ptr) + i;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      w_sel = PW'(w_idx);
      if (!w_found && bus.i_req[w_sel]) begin
        w_found  = 1'b1;
        w_winner = w_sel;
      end
    end
  end

  assign w_address  = bus.i_req_address[int'(w_winner)*AW +: AW];
  assign w_count    = bus.i_req_count[int'(w_winner)*AW +: AW];
  assign w_legal    = (w_count != '0) && (w_count <= AW'(BUFFER_SIZE));
  assign w_next_ptr = (r_owner == PW'(NUM_REQ-1)) ? '0 : r_owner + 1'b1;

  // Rejected counts skip WAIT and complete straight away with the error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_owner    <= '0;
      r_timer    <= '0;
      r_grant    <= '0;
      r_done     <= '0;
      r_error    <= 1'b0;
      r_busy     <= 1'b0;
      r_dma_read <= 1'b0;
      r_address  <= '0;
      r_count    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done  <= '0;
          r_error <= 1'b0;
          if (w_found) begin
            r_grant   <= NUM_REQ'(1) << w_winner;
            r_owner   <= w_winner;
            r_address <= w_address;
            r_count   <= w_count;
            r_busy    <= 1'b1;
            if (w_legal) begin
              r_dma_read <= 1'b1;
              r_timer    <= '0;
              r_state    <= S_WAIT;
            end else begin
              r_done  <= NUM_REQ'(1) << w_winner;
              r_error <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_WAIT: begin
          r_dma_read <= 1'b0;
          if (bus.i_dma_ready) begin
            r_done  <= r_grant;
            r_error <= 1'b0;
            r_state <= S_DONE;
          end else if (r_timer == TW'(TIMEOUT-1)) begin
            r_done  <= r_grant;
            r_error <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_DONE: begin
          r_done  <= '0;
          r_error <= 1'b0;
          r_grant <= '0;
          r_busy  <= 1'b0;
          r_ptr   <= w_next_ptr;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_grant       = r_grant;
  assign bus.o_done        = r_done;
  assign bus.o_error       = r_error;
  assign bus.o_busy        = r_busy;
  assign bus.o_dma_read    = r_dma_read;
  assign bus.o_dma_address = r_address;
  assign bus.o_dma_count   = r_count;
endmodule

// File: tb/tb_dma_arbiter.sv
// Scoreboard bench for dma_arbiter: each completion pops the expected
// {done, error, address, count} pushed when its request was driven.
module tb_dma_arbiter;
  localparam int NR = 2;
  localparam int AW = 10;
  localparam int BS = 120;
  localparam int TO = 1023;
  localparam int EW = NR + 1 + 2*AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  logic [EW-1:0] sbQ[$];

  dma_arbiter_if #(.NUM_REQ(NR), .MEM_ADDRESS_WIDTH(AW)) bus ();

  dma_arbiter #(.NUM_REQ(NR), .MEM_ADDRESS_WIDTH(AW), .BUFFER_SIZE(BS), .TIMEOUT(TO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // Request descriptor setup; the expected completion goes on the scoreboard here.
  task automatic applyStimulus(input int r, input logic [AW-1:0] a, input logic [AW-1:0] c, input logic e);
    bus.i_req_address[r*AW +: AW] = a;
    bus.i_req_count[r*AW +: AW]   = c;
    sbQ.push_back({NR'(1) << r, e, a, c});
  endtask

  function automatic logic [EW-1:0] popExpected();
    if (sbQ.size() == 0) return '1;
    return sbQ.pop_front();
  endfunction

  task automatic waitGrant(input int budget, output int cycles, output bit ok);
    cycles = 0;
    ok = 1'b0;
    while (cycles < budget && !ok) begin
      @(negedge clk);
      cycles++;
      if (bus.o_grant != '0) ok = 1'b1;
    end
  endtask

  task automatic waitDone(input int budget, output int cycles, output bit ok);
    cycles = 0;
    ok = 1'b0;
    while (cycles < budget && !ok) begin
      @(negedge clk);
      cycles++;
      if (bus.o_done != '0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [EW+1:0] obs;
    rst = 1'b1;
    bus.i_req = '0;
    bus.i_req_address = '0;
    bus.i_req_count = '0;
    bus.i_dma_ready = 1'b0;
    repeat (3) @(negedge clk);
    obs = {bus.o_grant, bus.o_done, bus.o_error, bus.o_busy, bus.o_dma_read, bus.o_dma_address, bus.o_dma_count};
    tests++;
    if (obs !== '0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got %h expected 0", obs);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int cyc;
    bit ok;
    logic [EW-1:0] obs, expv;
    applyStimulus(0, 10'h010, 10'd4, 1'b0);
    bus.i_req = 2'b01;
    waitGrant(5, cyc, ok);
    tests++;
    if (!ok || cyc != 1) begin
      fails++;
      $display("[TB] FAIL single_grant_latency: got %0d cycles (seen=%0d) expected 1", cyc, ok);
    end
    tests++;
    if ({bus.o_grant, bus.o_dma_read, bus.o_busy} !== 4'b0111) begin
      fails++;
      $display("[TB] FAIL single_grant_read: got %b expected 0111", {bus.o_grant, bus.o_dma_read, bus.o_busy});
    end
    @(negedge clk);
    tests++;
    if (bus.o_dma_read !== 1'b0) begin
      fails++;
      $display("[TB] FAIL single_read_pulse: got %b expected 0", bus.o_dma_read);
    end
    repeat (4) @(negedge clk);
    bus.i_dma_ready = 1'b1;
    @(negedge clk);
    bus.i_dma_ready = 1'b0;
    bus.i_req = '0;
    obs = {bus.o_done, bus.o_error, bus.o_dma_address, bus.o_dma_count};
    expv = popExpected();
    tests++;
    if (obs !== expv) begin
      fails++;
      $display("[TB] FAIL single_done: got %h expected %h", obs, expv);
    end
    @(negedge clk);
    tests++;
    if ({bus.o_done, bus.o_grant, bus.o_busy} !== 5'b0) begin
      fails++;
      $display("[TB] FAIL single_release: got %b expected 00000", {bus.o_done, bus.o_grant, bus.o_busy});
    end
  endtask

  task automatic test_round_robin();
    int order[4] = '{0, 1, 0, 1};
    int cyc;
    bit ok;
    logic [EW-1:0] obs, expv;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int t = 0; t < 4; t++)
      applyStimulus(order[t], (order[t] == 0) ? 10'h100 : 10'h200, (order[t] == 0) ? 10'd8 : 10'd16, 1'b0);
    bus.i_req = 2'b11;
    for (int t = 0; t < 4; t++) begin
      waitGrant(5, cyc, ok);
      tests++;
      if (!ok || bus.o_grant !== (NR'(1) << order[t])) begin
        fails++;
        $display("[TB] FAIL rr_grant_%0d: got %b expected %b", t, bus.o_grant, NR'(1) << order[t]);
      end
      bus.i_dma_ready = 1'b1;
      @(negedge clk);
      bus.i_dma_ready = 1'b0;
      if (t == 3) bus.i_req = '0;
      obs = {bus.o_done, bus.o_error, bus.o_dma_address, bus.o_dma_count};
      expv = popExpected();
      tests++;
      if (obs !== expv) begin
        fails++;
        $display("[TB] FAIL rr_done_%0d: got %h expected %h", t, obs, expv);
      end
      @(negedge clk);
      tests++;
      if (bus.o_busy !== 1'b0) begin
        fails++;
        $display("[TB] FAIL rr_idle_gap_%0d: got busy %b expected 0", t, bus.o_busy);
      end
    end
  endtask

  task automatic test_reject();
    logic [AW-1:0] badCounts[2] = '{10'd0, 10'd121};
    int cyc;
    bit ok;
    logic [EW-1:0] obs, expv;
    for (int t = 0; t < 2; t++) begin
      applyStimulus(1, 10'h033, badCounts[t], 1'b1);
      bus.i_req = 2'b10;
      @(negedge clk);
      bus.i_req = '0;
      obs = {bus.o_done, bus.o_error, bus.o_dma_address, bus.o_dma_count};
      expv = popExpected();
      tests++;
      if (obs !== expv) begin
        fails++;
        $display("[TB] FAIL reject_done_%0d: got %h expected %h", t, obs, expv);
      end
      tests++;
      if ({bus.o_grant, bus.o_dma_read} !== 3'b100) begin
        fails++;
        $display("[TB] FAIL reject_no_read_%0d: got %b expected 100", t, {bus.o_grant, bus.o_dma_read});
      end
      repeat (2) @(negedge clk);
    end
    applyStimulus(1, 10'h044, 10'd120, 1'b0);
    bus.i_req = 2'b10;
    waitGrant(5, cyc, ok);
    tests++;
    if (!ok || bus.o_dma_read !== 1'b1) begin
      fails++;
      $display("[TB] FAIL max_count_read: got %b expected 1", bus.o_dma_read);
    end
    bus.i_dma_ready = 1'b1;
    @(negedge clk);
    bus.i_dma_ready = 1'b0;
    bus.i_req = '0;
    obs = {bus.o_done, bus.o_error, bus.o_dma_address, bus.o_dma_count};
    expv = popExpected();
    tests++;
    if (obs !== expv) begin
      fails++;
      $display("[TB] FAIL max_count_done: got %h expected %h", obs, expv);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int cyc;
    bit ok;
    logic [EW-1:0] obs, expv;
    applyStimulus(0, 10'h2A0, 10'd50, 1'b1);
    bus.i_req = 2'b01;
    waitGrant(5, cyc, ok);
    applyStimulus(1, 10'h155, 10'd7, 1'b0);
    bus.i_req = 2'b11;
    waitDone(TO + 50, cyc, ok);
    bus.i_req = 2'b10;
    tests++;
    if (!ok || cyc != TO) begin
      fails++;
      $display("[TB] FAIL timeout_cycles: got %0d (seen=%0d) expected %0d", cyc, ok, TO);
    end
    obs = {bus.o_done, bus.o_error, bus.o_dma_address, bus.o_dma_count};
    expv = popExpected();
    tests++;
    if (obs !== expv) begin
      fails++;
      $display("[TB] FAIL timeout_done: got %h expected %h", obs, expv);
    end
    waitGrant(5, cyc, ok);
    tests++;
    if (!ok || cyc != 2 || bus.o_grant !== 2'b10) begin
      fails++;
      $display("[TB] FAIL timeout_next_grant: got %b after %0d cycles expected 10 after 2", bus.o_grant, cyc);
    end
    bus.i_dma_ready = 1'b1;
    @(negedge clk);
    bus.i_dma_ready = 1'b0;
    bus.i_req = '0;
    obs = {bus.o_done, bus.o_error, bus.o_dma_address, bus.o_dma_count};
    expv = popExpected();
    tests++;
    if (obs !== expv) begin
      fails++;
      $display("[TB] FAIL timeout_next_done: got %h expected %h", obs, expv);
    end
    @(negedge clk);
  endtask

  task automatic test_rst_mid();
    int cyc;
    bit ok;
    int stray;
    logic [EW-1:0] obs, expv;
    logic [EW+1:0] outs;
    applyStimulus(0, 10'h011, 10'd2, 1'b0);
    bus.i_req = 2'b01;
    waitGrant(5, cyc, ok);
    bus.i_dma_ready = 1'b1;
    @(negedge clk);
    bus.i_dma_ready = 1'b0;
    bus.i_req = '0;
    obs = {bus.o_done, bus.o_error, bus.o_dma_address, bus.o_dma_count};
    expv = popExpected();
    tests++;
    if (obs !== expv) begin
      fails++;
      $display("[TB] FAIL rst_pre_done: got %h expected %h", obs, expv);
    end
    @(negedge clk);
    applyStimulus(1, 10'h0AA, 10'd3, 1'b0);
    bus.i_req = 2'b10;
    waitGrant(5, cyc, ok);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.i_req = '0;
    sbQ.delete();
    outs = {bus.o_grant, bus.o_done, bus.o_error, bus.o_busy, bus.o_dma_read, bus.o_dma_address, bus.o_dma_count};
    tests++;
    if (outs !== '0) begin
      fails++;
      $display("[TB] FAIL rst_mid_outputs: got %h expected 0", outs);
    end
    stray = 0;
    bus.i_dma_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.o_done !== '0 || bus.o_busy !== 1'b0) stray++;
    end
    bus.i_dma_ready = 1'b0;
    tests++;
    if (stray != 0) begin
      fails++;
      $display("[TB] FAIL rst_stale_ready: got %0d active cycles expected 0", stray);
    end
    applyStimulus(0, 10'h0C0, 10'd5, 1'b0);
    bus.i_req = 2'b11;
    waitGrant(5, cyc, ok);
    tests++;
    if (!ok || bus.o_grant !== 2'b01) begin
      fails++;
      $display("[TB] FAIL rst_pointer: got grant %b expected 01", bus.o_grant);
    end
    bus.i_dma_ready = 1'b1;
    @(negedge clk);
    bus.i_dma_ready = 1'b0;
    bus.i_req = '0;
    obs = {bus.o_done, bus.o_error, bus.o_dma_address, bus.o_dma_count};
    expv = popExpected();
    tests++;
    if (obs !== expv) begin
      fails++;
      $display("[TB] FAIL rst_post_done: got %h expected %h", obs, expv);
    end
    @(negedge clk);
  endtask

  task automatic test_ready_at_timeout();
    int cyc;
    bit ok;
    int drift;
    logic [EW-1:0] obs, expv;
    applyStimulus(1, 10'h3C0, 10'd120, 1'b0);
    bus.i_req = 2'b10;
    waitGrant(5, cyc, ok);
    bus.i_req = '0;
    bus.i_req_address[AW +: AW] = 10'h001;
    bus.i_req_count[AW +: AW]   = 10'd9;
    drift = 0;
    for (int i = 1; i < TO; i++) begin
      @(negedge clk);
      if (bus.o_dma_address !== 10'h3C0 || bus.o_dma_count !== 10'd120 || bus.o_grant !== 2'b10) drift++;
    end
    tests++;
    if (drift != 0) begin
      fails++;
      $display("[TB] FAIL grant_fields_stable: got %0d changed cycles expected 0", drift);
    end
    bus.i_dma_ready = 1'b1;
    @(negedge clk);
    bus.i_dma_ready = 1'b0;
    obs = {bus.o_done, bus.o_error, bus.o_dma_address, bus.o_dma_count};
    expv = popExpected();
    tests++;
    if (obs !== expv) begin
      fails++;
      $display("[TB] FAIL ready_wins_timeout: got %h expected %h", obs, expv);
    end
    @(negedge clk);
    tests++;
    if ({bus.o_done, bus.o_error, bus.o_grant} !== 5'b0) begin
      fails++;
      $display("[TB] FAIL done_single_pulse: got %b expected 00000", {bus.o_done, bus.o_error, bus.o_grant});
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_reject();
    test_timeout();
    test_rst_mid();
    test_ready_at_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
